// File: rtl/tt_uart_tx_fifo.sv
// UART 8N1 transmitter fed by a small power-of-two byte FIFO.
// Frames start only from IDLE with ena=1; each frame is 10 bit periods plus one IDLE cycle.
module tt_uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DEPTH        = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       tx,
    output logic       busy,
    output logic [2:0] fifo_count
);

    localparam int               PTR_W  = $clog2(DEPTH);
    localparam int               CNT_W  = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       FULL   = 3'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t           state;
    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [2:0]       count;
    logic [CNT_W-1:0] bit_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             push;
    logic             pop;

    // Ready looks only at the registered count, so a pop on this edge never opens a slot early.
    assign in_ready   = (count < FULL);
    assign push       = in_valid && in_ready;
    assign pop        = (state == IDLE) && ena && (count != 3'd0);
    assign fifo_count = count;

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    // Each state holds its line level for CLKS_PER_BIT cycles: the counter reloads with
    // CLKS_PER_BIT-1 on every bit boundary and the transition fires when it reaches zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            tx      <= 1'b1;
            busy    <= 1'b0;
            bit_cnt <= RELOAD;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        state   <= START;
                        busy    <= 1'b1;
                        tx      <= 1'b0;
                        shreg   <= mem[rd_ptr];
                        bit_cnt <= RELOAD;
                    end
                end
                START: begin
                    if (bit_cnt == '0) begin
                        state   <= DATA;
                        tx      <= shreg[0];
                        shreg   <= {1'b0, shreg[7:1]};
                        bit_idx <= '0;
                        bit_cnt <= RELOAD;
                    end else begin
                        bit_cnt <= bit_cnt - CNT_W'(1);
                    end
                end
                DATA: begin
                    if (bit_cnt == '0) begin
                        bit_cnt <= RELOAD;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            tx      <= shreg[0];
                            shreg   <= {1'b0, shreg[7:1]};
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt - CNT_W'(1);
                    end
                end
                STOP: begin
                    if (bit_cnt == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        bit_cnt <= bit_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tt_uart_tx_fifo.sv
// Bench for tt_uart_tx_fifo: queue/timeline reference model, per-cycle compare, line decoder,
// directed scenarios with literal expectations, and a randomized push/ena stream.
module tb_tt_uart_tx_fifo;
    localparam int C = 4;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       tx;
    logic       busy;
    logic [2:0] fifo_count;

    always #5 clk = ~clk;

    tt_uart_tx_fifo #(.CLKS_PER_BIT(C), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .ena(ena), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .tx(tx), .busy(busy), .fifo_count(fifo_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO as a queue, frame as elapsed time since its start edge.
    logic [7:0] mq[$];
    logic [7:0] acc[$];
    logic [7:0] m_cur = 8'h00;
    bit         m_act = 1'b0;
    int         m_t = 0;
    int         cyc = 0;
    bit         chk_en = 1'b0;
    bit         dec_abort = 1'b0;

    always @(posedge clk) begin
        bit push_ok;
        bit start;
        cyc++;
        if (rst) begin
            mq.delete();
            m_act = 1'b0;
            m_t = 0;
            chk_en = 1'b1;
            dec_abort = 1'b1;
        end else begin
            push_ok = in_valid && (mq.size() < D);
            start = !m_act && ena && (mq.size() > 0);
            if (m_act) begin
                m_t++;
                if (m_t == 10 * C) m_act = 1'b0;
            end else if (start) begin
                m_cur = mq.pop_front();
                m_act = 1'b1;
                m_t = 0;
            end
            if (push_ok) begin
                mq.push_back(in_data);
                acc.push_back(in_data);
            end
        end
    end

    function automatic logic exp_tx();
        int slot;
        if (!m_act) return 1'b1;
        slot = m_t / C;
        if (slot == 0) return 1'b0;
        if (slot >= 9) return 1'b1;
        return m_cur[slot-1];
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("tx", int'(tx), int'(exp_tx()));
            check("busy", int'(busy), int'(m_act));
            check("fifo_count", int'(fifo_count), mq.size());
            check("in_ready", int'(in_ready), int'(mq.size() < D));
        end
    end

    // Line decoder on the DUT tx pin, sampling mid-bit.
    logic [7:0] dec[$];
    int         dec_cyc[$];
    bit         d_on = 1'b0;
    int         d_k = 0;
    logic [7:0] d_b = 8'h00;

    always @(negedge clk) begin
        if (dec_abort) begin
            d_on = 1'b0;
            dec_abort = 1'b0;
        end else if (chk_en) begin
            if (!d_on) begin
                if (tx == 1'b0) begin
                    d_on = 1'b1;
                    d_k = 0;
                    dec_cyc.push_back(cyc);
                end
            end else begin
                d_k++;
                if (d_k == 9 * C + C / 2) begin
                    check("stop_bit", int'(tx), 1);
                    dec.push_back(d_b);
                    d_on = 1'b0;
                end else if (d_k >= C + C / 2 && ((d_k - C / 2) % C) == 0) begin
                    d_b[3'((d_k - C / 2) / C - 1)] = tx;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    logic       txs [42];
    logic [0:9] pat;
    int         nb;
    int         n0;
    int         guard;

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_tx", int'(tx), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_count", int'(fifo_count), 0);
        check("rst_ready", int'(in_ready), 1);

        // 0xA5 frame, literal slot pattern
        pat = 10'b0101001011;
        ena = 1'b1; in_data = 8'hA5; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        nb = 0;
        for (int k = 0; k < 42; k++) begin
            @(negedge clk);
            txs[k] = tx;
            if (busy) nb++;
        end
        for (int s = 0; s < 10; s++)
            check($sformatf("a5_slot%0d", s), int'(txs[s*C + C/2]), int'(pat[s]));
        check("a5_busy_len", nb, 40);
        check("a5_idle_tx", int'(txs[41]), 1);

        // fill while disabled, then drain
        ena = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            in_data = 8'(i); in_valid = 1'b1;
            if (i == 5) check("full_ready", int'(in_ready), 0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("full_count", int'(fifo_count), 4);
        n0 = dec.size();
        ena = 1'b1;
        repeat (4 * 41 + 45) @(negedge clk);
        check("fill_frames", dec.size() - n0, 4);
        if (dec.size() - n0 == 4) begin
            for (int j = 0; j < 4; j++) check($sformatf("fill_byte%0d", j), int'(dec[n0+j]), j + 1);
            for (int j = 1; j < 4; j++) check($sformatf("fill_gap%0d", j), dec_cyc[n0+j] - dec_cyc[n0+j-1], 41);
        end
        check("fill_empty", int'(fifo_count), 0);

        // push on the pop edge
        ena = 1'b0; in_data = 8'h3C; in_valid = 1'b1;
        @(negedge clk);
        n0 = dec.size();
        in_data = 8'hC3; ena = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("samepop_count", int'(fifo_count), 1);
        repeat (2 * 41 + 20) @(negedge clk);
        check("samepop_frames", dec.size() - n0, 2);
        if (dec.size() - n0 == 2) begin
            check("samepop_b0", int'(dec[n0]), 8'h3C);
            check("samepop_b1", int'(dec[n0+1]), 8'hC3);
        end

        // reset at the middle of data bit 3
        n0 = dec.size();
        in_data = 8'h5A; in_valid = 1'b1;
        @(negedge clk);
        in_data = 8'h77;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (18) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_tx", int'(tx), 1);
        check("midrst_busy", int'(busy), 0);
        check("midrst_count", int'(fifo_count), 0);
        nb = 0;
        repeat (60) begin
            @(negedge clk);
            if (busy) nb++;
        end
        check("midrst_no_frame", nb, 0);
        check("midrst_no_byte", dec.size() - n0, 0);

        // ena dropped during START
        n0 = dec.size();
        in_data = 8'h11; in_valid = 1'b1;
        @(negedge clk);
        in_data = 8'h22;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        ena = 1'b0;
        repeat (60) @(negedge clk);
        check("hold_busy", int'(busy), 0);
        check("hold_count", int'(fifo_count), 1);
        check("hold_frames", dec.size() - n0, 1);
        if (dec.size() > n0) check("hold_b0", int'(dec[n0]), 8'h11);
        ena = 1'b1;
        @(negedge clk);
        check("resume_tx", int'(tx), 0);
        repeat (50) @(negedge clk);
        check("resume_frames", dec.size() - n0, 2);
        if (dec.size() - n0 == 2) check("resume_b1", int'(dec[n0+1]), 8'h22);

        // randomized stream of 200 accepted bytes
        acc.delete(); dec.delete(); dec_cyc.delete();
        guard = 0;
        while (acc.size() < 200 && guard < 30000) begin
            in_data = 8'($urandom);
            in_valid = ($urandom_range(0, 15) == 0) || ((guard % 1000) < 100);
            ena = ($urandom_range(0, 7) != 0);
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b0;
        ena = 1'b1;
        check("rand_accept_200", int'(acc.size() >= 200), 1);
        guard = 0;
        while ((m_act || mq.size() > 0) && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        repeat (50) @(negedge clk);
        check("rand_drained", int'(guard < 1000), 1);
        check("rand_count", dec.size(), acc.size());
        for (int i = 0; i < acc.size() && i < dec.size(); i++)
            check($sformatf("rand_byte%0d", i), int'(dec[i]), int'(acc[i]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
